spike_rate_decoder: RTL and testbench
=====================================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of rate/ISI/window counters and outputs.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high; one clock domain.
REQ-004 enable  input  1  1 = decode active; 0 = abort and idle.
REQ-005 spike_in  input  1  spike level from an LIF neuron, synchronous to clk.
REQ-006 win_len  input  CNT_W  window length in cycles; 0 means 2^CNT_W; sampled only at window start.
REQ-007 rate_out  output  CNT_W  rising-edge count of the last completed window.
REQ-008 rate_valid  output  1  rate_out holds an unaccepted result.
REQ-009 rate_ready  input  1  consumer accepts rate_out when rate_valid and rate_ready are both 1.
REQ-010 isi_out  output  CNT_W  last inter-spike interval in cycles, saturating.
REQ-011 isi_valid  output  1  single-cycle pulse when isi_out updates.
REQ-012 overrun  output  1  sticky; an unaccepted rate result was overwritten.

Function
REQ-013 Spike event: rising edge only, i.e. spike_in=1 while the registered previous sample=0; a held-high spike counts once.
REQ-014 Previous-sample register resets to 0 and updates every cycle regardless of enable.
REQ-015 FSM states: IDLE, COUNT. IDLE->COUNT when enable=1; COUNT->IDLE when enable=0; no other transitions.
REQ-016 On IDLE->COUNT: latch win_len (0 -> 2^CNT_W) into win_lat; clear win_cnt and spike_cnt.
REQ-017 In COUNT, win_cnt increments every cycle; the window ends in the cycle where win_cnt = win_lat-1.
REQ-018 spike_cnt increments per event and saturates at 2^CNT_W-1.
REQ-019 Window end: result = spike_cnt plus the event in that same cycle, saturated; registered into rate_out with rate_valid=1 on the next edge. Latency: 1 cycle from the last window cycle.
REQ-020 Window end also clears win_cnt and spike_cnt, re-latches win_len, and starts the next window back-to-back with no gap cycle.
REQ-021 rate_valid/rate_out hold stable until the handshake completes; rate_valid clears on the edge after the handshake.
REQ-022 New result while rate_valid=1 and no handshake in that cycle: overwrite rate_out, keep rate_valid=1, set overrun=1.
REQ-023 Handshake in the same cycle as a new result: load the new result, keep rate_valid=1, no overrun.
REQ-024 overrun clears only on rst.
REQ-025 ISI: isi_cnt counts cycles since the last event, saturating at 2^CNT_W-1. On an event with a prior event recorded: isi_out <= isi_cnt+1 (saturated), isi_valid pulses 1 cycle, isi_cnt <= 0.
REQ-026 The first event after reset or after entering COUNT only arms the ISI measurement; it produces no isi_valid.
REQ-027 enable=0 mid-window: discard the partial window and disarm ISI. No rate result. A rate_valid/rate_out already pending stays held until accepted.
REQ-028 In IDLE, events are ignored and isi_valid=0.

Reset
REQ-029 On rst=1, immediately and regardless of clk: FSM=IDLE, all counters=0, rate_out=0, rate_valid=0, isi_out=0, isi_valid=0, overrun=0, ISI disarmed.
REQ-030 rst asserted mid-window or with a pending result loses all state; after release, operation restarts only via REQ-016.

Verification
REQ-031 win_len=10, enable=1, 1-cycle spikes every 3rd cycle starting at cycle 0, rate_ready=1 -> rate_out=4, rate_valid for 1 cycle every 10 cycles; isi_out=3 with isi_valid per spike from the 2nd spike on.
REQ-032 spike_in held high 5 cycles within win_len=8 -> rate_out=1, no isi_valid.
REQ-033 win_len=4, rate_ready=0 over two windows -> rate_valid stays 1, rate_out=2nd result, overrun=1. Raise rate_ready -> rate_valid drops the next cycle; overrun stays 1.
REQ-034 win_len=0, spike_in toggling every cycle (128 edges) -> rate_out=128 after 256 cycles; spike every 300 cycles -> isi_out=255 (saturated).
REQ-035 enable dropped at win_cnt=5 of win_len=10, then re-raised -> no rate_valid for the aborted window; the first spike after re-enable gives no isi_valid.
REQ-036 rst pulsed between clk edges mid-window with rate_valid=1 -> all outputs 0 immediately; no result appears until 1 full window after the next enable.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts rising edges of an LIF spike level over fixed
// windows (rate, valid/ready output) and measures inter-spike intervals.
module spike_rate_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [CNT_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic [CNT_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             overrun
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W:0]   WIN_ONE = 1;

    state_t           state, state_nxt;
    logic             spike_prev;
    logic             spike_event;
    logic             active;
    logic             win_end;
    logic             handshake;
    logic [CNT_W:0]   win_lat;
    logic [CNT_W:0]   win_len_eff;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] spike_cnt;
    logic [CNT_W-1:0] result;
    logic [CNT_W-1:0] isi_cnt;
    logic             isi_armed;

    assign spike_event = spike_in & ~spike_prev;
    assign active      = (state == COUNT) && enable;
    // win_lat is one bit wider so that win_len=0 can stand for a full 2^CNT_W window
    assign win_len_eff = (win_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, win_len};
    assign win_end     = active && ({1'b0, win_cnt} == (win_lat - WIN_ONE));
    assign result      = (spike_event && spike_cnt != CNT_MAX) ? spike_cnt + CNT_ONE : spike_cnt;
    assign handshake   = rate_valid && rate_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) spike_prev <= 1'b0;
        else     spike_prev <= spike_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = COUNT;
            COUNT:   if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Window and spike counters; each window end re-arms the next window back-to-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_lat   <= '0;
            win_cnt   <= '0;
            spike_cnt <= '0;
        end else if (state == IDLE) begin
            if (enable) begin
                win_lat   <= win_len_eff;
                win_cnt   <= '0;
                spike_cnt <= '0;
            end
        end else if (enable) begin
            if (win_end) begin
                win_lat   <= win_len_eff;
                win_cnt   <= '0;
                spike_cnt <= '0;
            end else begin
                win_cnt   <= win_cnt + CNT_ONE;
                spike_cnt <= result;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_out   <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (win_end) begin
            rate_out   <= result;
            rate_valid <= 1'b1;
            if (rate_valid && !rate_ready) overrun <= 1'b1;
        end else if (handshake) begin
            rate_valid <= 1'b0;
        end
    end

    // Leaving COUNT (or never being in it) disarms, so the next first spike only arms
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isi_cnt   <= '0;
            isi_armed <= 1'b0;
            isi_out   <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (!active) begin
                isi_cnt   <= '0;
                isi_armed <= 1'b0;
            end else if (spike_event) begin
                if (isi_armed) begin
                    isi_out   <= (isi_cnt == CNT_MAX) ? CNT_MAX : isi_cnt + CNT_ONE;
                    isi_valid <= 1'b1;
                end
                isi_cnt   <= '0;
                isi_armed <= 1'b1;
            end else if (isi_cnt != CNT_MAX) begin
                isi_cnt <= isi_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_spike_rate_decoder;

    logic       clk, rst, enable, spike_in, rate_ready;
    logic [7:0] win_len;
    logic [7:0] rate_out, isi_out;
    logic       rate_valid, isi_valid, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    spike_rate_decoder #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .spike_in(spike_in),
        .win_len(win_len), .rate_out(rate_out), .rate_valid(rate_valid),
        .rate_ready(rate_ready), .isi_out(isi_out), .isi_valid(isi_valid),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks event timestamps and elapsed window time
    int m_cyc, m_last, m_len, m_elapsed, m_cnt, m_res;
    bit m_prev, m_run, m_ev, m_done;
    int e_rate, e_rv, e_isi, e_iv, e_ovr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev = 0; m_run = 0; m_last = -1; m_elapsed = 0; m_cnt = 0;
            e_rate <= 0; e_rv <= 0; e_isi <= 0; e_iv <= 0; e_ovr <= 0;
        end else begin
            m_ev   = spike_in && !m_prev;
            m_prev = spike_in;
            m_done = 0;
            e_iv  <= 0;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1; m_elapsed = 0; m_cnt = 0; m_last = -1;
                    m_len = (win_len == 0) ? 256 : int'(win_len);
                end
            end else if (!enable) begin
                m_run = 0;
            end else begin
                if (m_ev) begin
                    m_cnt++;
                    if (m_last >= 0) begin
                        e_isi <= (m_cyc - m_last > 255) ? 255 : m_cyc - m_last;
                        e_iv  <= 1;
                    end
                    m_last = m_cyc;
                end
                m_elapsed++;
                if (m_elapsed == m_len) begin
                    m_done = 1;
                    m_res = (m_cnt > 255) ? 255 : m_cnt;
                    m_elapsed = 0; m_cnt = 0;
                    m_len = (win_len == 0) ? 256 : int'(win_len);
                end
            end
            if (m_done) begin
                e_rate <= m_res;
                e_rv   <= 1;
                if (e_rv != 0 && !rate_ready) e_ovr <= 1;
            end else if (e_rv != 0 && rate_ready) begin
                e_rv <= 0;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rate_out",   int'(rate_out),   e_rate);
            chk("rate_valid", int'(rate_valid), e_rv);
            chk("isi_out",    int'(isi_out),    e_isi);
            chk("isi_valid",  int'(isi_valid),  e_iv);
            chk("overrun",    int'(overrun),    e_ovr);
        end
    end

    // Drive inputs for one cycle starting at a negedge; returns at the next negedge
    task automatic tick(input logic s);
        spike_in = s;
        @(negedge clk);
    endtask

    initial begin
        m_cyc = 0;
        rst = 1'b1; enable = 1'b0; spike_in = 1'b0; rate_ready = 1'b1; win_len = 8'd10;
        @(negedge clk);
        @(negedge clk);
        chk("reset rate_valid", int'(rate_valid), 0);
        chk("reset overrun",    int'(overrun),    0);
        chk("reset rate_out",   int'(rate_out),   0);
        rst = 1'b0;
        tick(1'b0);

        // Periodic spikes every 3rd cycle, 10-cycle windows
        enable = 1'b1; win_len = 8'd10;
        tick(1'b0);
        for (int i = 0; i < 40; i++) begin
            tick(i % 3 == 0);
            if (i == 0) chk("periodic first spike no isi", int'(isi_valid), 0);
            if (i == 3) begin
                chk("periodic isi_out", int'(isi_out), 3);
                chk("periodic isi_valid", int'(isi_valid), 1);
            end
            if (i == 8)  chk("periodic no early result", int'(rate_valid), 0);
            if (i == 9) begin
                chk("periodic rate_out", int'(rate_out), 4);
                chk("periodic rate_valid", int'(rate_valid), 1);
            end
            if (i == 10) chk("periodic valid one cycle", int'(rate_valid), 0);
        end
        enable = 1'b0;
        tick(1'b0);

        // Held-high spike counts once
        enable = 1'b1; win_len = 8'd8;
        tick(1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(i >= 1 && i <= 5);
            chk("held no isi_valid", int'(isi_valid), 0);
        end
        chk("held rate_out", int'(rate_out), 1);
        enable = 1'b0;
        tick(1'b0);

        // Unaccepted results over two windows -> overrun
        rate_ready = 1'b0; enable = 1'b1; win_len = 8'd4;
        tick(1'b0);
        for (int i = 0; i < 8; i++) tick(i == 0 || i == 4 || i == 6);
        chk("overrun rate_out", int'(rate_out), 2);
        chk("overrun rate_valid", int'(rate_valid), 1);
        chk("overrun flag", int'(overrun), 1);
        rate_ready = 1'b1; enable = 1'b0;
        tick(1'b0);
        chk("overrun accept drops valid", int'(rate_valid), 0);
        chk("overrun sticky", int'(overrun), 1);
        tick(1'b0);

        // win_len=0 -> 256-cycle window; then saturating ISI
        enable = 1'b1; win_len = 8'd0;
        tick(1'b0);
        for (int i = 0; i < 256; i++) tick(i % 2 == 0);
        chk("full window rate_out", int'(rate_out), 128);
        for (int j = 0; j < 660; j++) begin
            tick(j % 300 == 0);
            if (j == 300) begin
                chk("isi saturated out", int'(isi_out), 255);
                chk("isi saturated valid", int'(isi_valid), 1);
            end
        end

        // Abort mid-window, then re-enable
        enable = 1'b0;
        tick(1'b0); tick(1'b0);
        enable = 1'b1; win_len = 8'd10;
        tick(1'b0);
        for (int i = 0; i < 5; i++) tick(i == 1 || i == 3);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            chk("abort no rate_valid", int'(rate_valid), 0);
        end
        rate_ready = 1'b0; enable = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 15; i++) begin
            tick(i == 2 || i == 5);
            if (i == 2) chk("re-enable first spike no isi", int'(isi_valid), 0);
            if (i == 5) begin
                chk("re-enable isi_out", int'(isi_out), 3);
                chk("re-enable isi_valid", int'(isi_valid), 1);
            end
        end
        chk("pending before reset", int'(rate_valid), 1);

        // Asynchronous reset between edges with a result pending
        #2 rst = 1'b1;
        #1;
        chk("async rst rate_valid", int'(rate_valid), 0);
        chk("async rst rate_out",   int'(rate_out),   0);
        chk("async rst isi_out",    int'(isi_out),    0);
        chk("async rst overrun",    int'(overrun),    0);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            tick(i == 0);
            if (i < 9) chk("post rst no early result", int'(rate_valid), 0);
        end
        chk("post rst rate_valid", int'(rate_valid), 1);
        chk("post rst rate_out", int'(rate_out), 1);
        tick(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
